// File: rtl/cache_ctrl.sv
// Direct-mapped write-through no-allocate cache; hit 1 cycle, miss/write MEM_LAT+1; one request held until cpu_ready.
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count ports.
module cache_ctrl #(
  parameter int INDEX_W = 4,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] mem_addr,
  output logic        mem_rEnable,
  output logic        mem_wEnable,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t state, next_state;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic [3:0]         cnt;
  logic               wr_hit;
  logic [INDEX_W-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;
  logic               req_hit, accept, last;
  logic [1:0]         unused_addr_bits;

  assign req_idx          = cpu_addr[2 +: INDEX_W];
  assign req_tag          = cpu_addr[31 -: TAG_W];
  // mem_addr doubles as the latched request address for the line update
  assign lat_idx          = mem_addr[2 +: INDEX_W];
  assign lat_tag          = mem_addr[31 -: TAG_W];
  assign req_hit          = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign accept           = (state == IDLE) && cpu_req;
  assign last             = (cnt == 4'(MEM_LAT - 1));
  assign unused_addr_bits = cpu_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mem_rEnable = 1'b0;
    mem_wEnable = 1'b0;
    cpu_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we)       next_state = WRITE;
          else if (req_hit) next_state = RESP;
          else              next_state = FILL;
        end
      end
      FILL: begin
        mem_rEnable = 1'b1;
        if (last) next_state = RESP;
      end
      WRITE: begin
        mem_wEnable = 1'b1;
        if (last) next_state = RESP;
      end
      RESP: begin
        cpu_ready  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      wr_hit    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cpu_rdata <= '0;
      valid     <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (cpu_we || !req_hit) mem_addr <= {cpu_addr[31:2], 2'b00};
      if (cpu_we) begin
        mem_din <= cpu_wdata;
        wr_hit  <= req_hit;
      end else if (req_hit) begin
        cpu_rdata <= data_arr[req_idx];
      end
    end else if (state == FILL || state == WRITE) begin
      cnt <= cnt + 4'd1;
      if (state == FILL && last) begin
        valid[lat_idx] <= 1'b1;
        cpu_rdata      <= mem_dout;
      end
    end
  end

  // Tag/data storage carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (state == FILL && last) begin
      tag_arr[lat_idx]  <= lat_tag;
      data_arr[lat_idx] <= mem_dout;
    end else if (state == WRITE && cnt == 4'd0 && wr_hit) begin
      data_arr[lat_idx] <= mem_din;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept && !cpu_we) begin
      if (req_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and `main_mem`. It serves read hits from an internal tag/data array. It drives `main_mem`'s `addr`/`rEnable`/`wEnable`/`din` and consumes `dout` on read misses and on every write. One outstanding request at a time, with a request/ready handshake toward the CPU.

## Interface
- `INDEX_W`, 4: index bits; `2**INDEX_W` lines, one 32-bit word per line
- `MEM_LAT`, 1: cycles a `main_mem` access is held (read data valid on the last held cycle); legal range 1–15
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  request valid; held high until `cpu_ready`
- `cpu_we`  in  1  1 = write, 0 = read; sampled with `cpu_req`
- `cpu_addr`  in  32  byte address; bits [1:0] ignored
- `cpu_wdata`  in  32  write data
- `cpu_rdata`  out  32  read data; valid while `cpu_ready` = 1
- `cpu_ready`  out  1  one-cycle completion pulse
- `mem_addr`  out  32  to `main_mem.addr`; `{cpu_addr[31:2],2'b00}`
- `mem_rEnable`  out  1  to `main_mem.rEnable`
- `mem_wEnable`  out  1  to `main_mem.wEnable`
- `mem_din`  out  32  to `main_mem.din`
- `mem_dout`  in  32  from `main_mem.dout`
- `hit_count`, `miss_count`  out  16 each  present only with `CACHE_STATS_EN`

## Operation
- Address split:
  - index = `cpu_addr[2 +: INDEX_W]`
  - tag = `cpu_addr[31:2+INDEX_W]`
  - per line: valid bit, tag, 32-bit data
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE with `cpu_req` = 1:
  - latch `cpu_addr`, `cpu_we` and `cpu_wdata`
  - read hit (valid and tag match) → load `cpu_rdata` from the array, go to RESP
  - read miss → FILL
  - write (hit or miss) → WRITE
- FILL:
  - `mem_rEnable` = 1 and `mem_addr` = latched address for `MEM_LAT` cycles
  - on the last cycle, capture `mem_dout` into the line (valid = 1, tag written) and into `cpu_rdata`, then go to RESP
- WRITE:
  - `mem_wEnable` = 1, `mem_addr`/`mem_din` = latched values for `MEM_LAT` cycles, then RESP
  - on a hit, the line data is updated in the first WRITE cycle
  - on a miss, the array is unchanged (no allocate)
- RESP: `cpu_ready` = 1 for exactly one cycle, then IDLE.
  - A `cpu_req` that is high during RESP is not accepted until the following IDLE cycle.
- `mem_rEnable` and `mem_wEnable` are never both 1.
  - Outside FILL/WRITE both are 0; `mem_addr`/`mem_din` hold their last values.
- `cpu_rdata` holds its value outside RESP. Its value after a write response is unspecified.

## Timing
- Reset (async assert, sync release) drives:
  - state = IDLE
  - all valid bits = 0
  - `cpu_ready` = 0, `cpu_rdata` = 0
  - `mem_rEnable` = 0, `mem_wEnable` = 0, `mem_addr` = 0, `mem_din` = 0
  - counters = 0
- Tag/data contents are not reset.
- Latency, with cycle 0 = the IDLE cycle in which `cpu_req` is sampled:
  - read hit: `cpu_ready` in cycle 1
  - read miss: FILL in cycles 1..`MEM_LAT`, `cpu_ready` in cycle `MEM_LAT`+1
  - write: WRITE in cycles 1..`MEM_LAT`, `cpu_ready` in cycle `MEM_LAT`+1
- Back-to-back requests: the earliest next acceptance is the cycle after RESP (read hit turnaround = 2 cycles).
- Reset mid-FILL or mid-WRITE:
  - memory enables drop immediately
  - no `cpu_ready` is issued
  - the line being filled stays invalid
- A read that follows a write to the same address returns the new data: from the array if the write hit, otherwise via FILL.
- `cpu_addr`, `cpu_we` and `cpu_wdata` changing after acceptance have no effect.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each accepted read hit
  - `miss_count` increments on each accepted read miss
  - both saturate at 16'hFFFF
  - writes are not counted
- `CACHE_STATS_EN` undefined: the counters and both ports are absent; all other behaviour is identical.

## Test plan
- Reset, then read 32'h0000_0040 with `main_mem` holding 32'h0221_7000 there:
  - `mem_rEnable` is high for `MEM_LAT` cycles
  - `cpu_ready` with `cpu_rdata` = 32'h0221_7000 in cycle `MEM_LAT`+1
  - `miss_count` = 1
- Read 32'h0000_0040 again:
  - `cpu_ready` in cycle 1 with 32'h0221_7000
  - no memory enable asserted
  - `hit_count` = 1
- Write 32'h0002_1A00 to 32'h0000_0040 (hit):
  - `mem_wEnable` high for `MEM_LAT` cycles with `mem_din` = 32'h0002_1A00
  - a following read hits and returns 32'h0002_1A00
- Write 32'h0000_1111 to 32'h0012_1800 (miss):
  - memory is written
  - a following read of 32'h0012_1800 misses and fills 32'h0000_1111
- Conflict: read 32'h0000_0040, then read 32'h0000_0080 (`INDEX_W`=4, same index, different tag):
  - the second read misses and evicts the line
  - a re-read of 32'h0000_0040 misses again
- Assert `rst_n` = 0 during FILL:
  - `mem_rEnable` falls within the same cycle
  - no `cpu_ready` is issued
  - a subsequent read of the same address misses
